// File: rtl/hdr_frame_writer_pkg.sv
// Purpose: shared types and constants for the header/payload frame writer.
//   - FSM state encoding
//   - default frame geometry and bus widths
//   - header word index map, shared with the header RAM contents
`timescale 1ns/1ps
package hdr_frame_writer_pkg;

  localparam int unsigned HDR_WORDS_DEF     = 4;
  localparam int unsigned PAYLOAD_WORDS_DEF = 256;
  localparam int unsigned DW_DEF            = 32;
  localparam int unsigned AW_DEF            = 4;

  // Header word positions within the header RAM
  localparam int unsigned HDR_W_RSVD0 = 0;
  localparam int unsigned HDR_W_FRAME = 1;
  localparam int unsigned HDR_W_PPS   = 2;
  localparam int unsigned HDR_W_RSVD3 = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HDR_SETUP = 2'd1,
    ST_HDR_PUSH  = 2'd2,
    ST_PAYLOAD   = 2'd3
  } state_e;

endpackage

// File: rtl/hdr_frame_writer.sv
// Purpose: per frame_start, copy HDR_WORDS header words from a combinational
//   header RAM into the host FIFO, then forward PAYLOAD_WORDS stream words.
//   FIFO backpressure is honoured in every state.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_frame_start                   1-cycle frame request (ignored and counted while busy)
//   o_hdr_addr, o_hdr_rd_en         header RAM read port
//   i_hdr_data                      header RAM data, combinational from o_hdr_addr
//   i_payload_data/valid, o_payload_ready   payload stream handshake
//   o_fifo_din, o_fifo_wr_en, i_fifo_full   FIFO write port
//   o_busy                          high outside IDLE
//   o_frames_sent                   completed frames (wrapping)
//   o_frames_dropped                ignored frame_start pulses (saturating)
`timescale 1ns/1ps
module hdr_frame_writer
  import hdr_frame_writer_pkg::*;
#(
  parameter int unsigned HDR_WORDS     = HDR_WORDS_DEF,
  parameter int unsigned PAYLOAD_WORDS = PAYLOAD_WORDS_DEF,
  parameter int unsigned DW            = DW_DEF,
  parameter int unsigned AW            = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_frame_start,
  output logic [AW-1:0] o_hdr_addr,
  output logic          o_hdr_rd_en,
  input  logic [DW-1:0] i_hdr_data,
  input  logic [DW-1:0] i_payload_data,
  input  logic          i_payload_valid,
  output logic          o_payload_ready,
  output logic [DW-1:0] o_fifo_din,
  output logic          o_fifo_wr_en,
  input  logic          i_fifo_full,
  output logic          o_busy,
  output logic [31:0]   o_frames_sent,
  output logic [15:0]   o_frames_dropped
);

  localparam int unsigned PCW = $clog2(PAYLOAD_WORDS + 1);

  state_e         r_state;
  state_e         w_next_state;
  logic [AW-1:0]  r_hidx;
  logic [PCW-1:0] r_pcnt;
  logic [DW-1:0]  r_hold;
  logic [31:0]    r_frames_sent;
  logic [15:0]    r_frames_dropped;

  logic w_hdr_last;
  logic w_pay_last;
  logic w_hdr_write;
  logic w_pay_accept;

  assign w_hdr_last   = (r_hidx == AW'(HDR_WORDS - 1));
  assign w_pay_last   = (r_pcnt == PCW'(PAYLOAD_WORDS - 1));
  assign w_hdr_write  = (r_state == ST_HDR_PUSH) && !i_fifo_full;
  assign w_pay_accept = (r_state == ST_PAYLOAD) && i_payload_valid && !i_fifo_full;

  assign o_hdr_addr       = r_hidx;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_frames_sent    = r_frames_sent;
  assign o_frames_dropped = r_frames_dropped;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and FIFO/RAM strobes
  always_comb begin
    w_next_state    = r_state;
    o_hdr_rd_en     = 1'b0;
    o_fifo_wr_en    = 1'b0;
    o_payload_ready = 1'b0;
    o_fifo_din      = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_start) w_next_state = ST_HDR_SETUP;
      end
      ST_HDR_SETUP: begin
        o_hdr_rd_en  = 1'b1;
        w_next_state = ST_HDR_PUSH;
      end
      ST_HDR_PUSH: begin
        o_hdr_rd_en  = 1'b1;
        o_fifo_wr_en = w_hdr_write;
        if (w_hdr_write) w_next_state = w_hdr_last ? ST_PAYLOAD : ST_HDR_SETUP;
      end
      ST_PAYLOAD: begin
        o_payload_ready = !i_fifo_full;
        o_fifo_din      = i_payload_data;
        o_fifo_wr_en    = w_pay_accept;
        if (w_pay_accept && w_pay_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Header index, hold register and payload counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hidx <= '0;
      r_pcnt <= '0;
      r_hold <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_frame_start) r_hidx <= '0;
        end
        ST_HDR_SETUP: r_hold <= i_hdr_data;
        ST_HDR_PUSH: begin
          if (w_hdr_write) begin
            if (w_hdr_last) begin
              r_hidx <= '0;
              r_pcnt <= '0;
            end else begin
              r_hidx <= r_hidx + AW'(1);
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_pay_accept) r_pcnt <= r_pcnt + PCW'(1);
        end
        default: ;
      endcase
    end
  end

  // Frame statistics; a start on the returning edge is still seen as busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frames_sent    <= '0;
      r_frames_dropped <= '0;
    end else begin
      if (w_pay_accept && w_pay_last) r_frames_sent <= r_frames_sent + 32'd1;
      if (i_frame_start && (r_state != ST_IDLE) && (r_frames_dropped != 16'hFFFF))
        r_frames_dropped <= r_frames_dropped + 16'd1;
    end
  end

endmodule

// File: tb/tb_hdr_frame_writer.sv
// Purpose: self-checking bench for hdr_frame_writer. Expected FIFO words are
//   queued when a frame is launched and popped as the DUT writes them.
`timescale 1ns/1ps
module tb_hdr_frame_writer;
  import hdr_frame_writer_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned HW = 4;
  localparam int unsigned PW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_frame_start = 1'b0;
  logic [AW-1:0] o_hdr_addr;
  logic          o_hdr_rd_en;
  logic [DW-1:0] i_hdr_data;
  logic [DW-1:0] i_payload_data = '0;
  logic          i_payload_valid = 1'b0;
  logic          o_payload_ready;
  logic [DW-1:0] o_fifo_din;
  logic          o_fifo_wr_en;
  logic          i_fifo_full = 1'b0;
  logic          o_busy;
  logic [31:0]   o_frames_sent;
  logic [15:0]   o_frames_dropped;

  int            n_vec = 0;
  int            n_err = 0;
  logic [31:0]   exp_q[$];
  int            pidx = 0;
  logic          tgl_mode = 1'b0;
  logic          rnd_full = 1'b0;
  logic          force_full = 1'b0;

  always #5 clk = ~clk;

  hdr_frame_writer #(.HDR_WORDS(HW), .PAYLOAD_WORDS(PW), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start),
    .o_hdr_addr(o_hdr_addr), .o_hdr_rd_en(o_hdr_rd_en), .i_hdr_data(i_hdr_data),
    .i_payload_data(i_payload_data), .i_payload_valid(i_payload_valid),
    .o_payload_ready(o_payload_ready), .o_fifo_din(o_fifo_din),
    .o_fifo_wr_en(o_fifo_wr_en), .i_fifo_full(i_fifo_full), .o_busy(o_busy),
    .o_frames_sent(o_frames_sent), .o_frames_dropped(o_frames_dropped)
  );

  // Header RAM contents: frame_count=0x11, pps_count=0x22
  function automatic logic [31:0] hdr_word(input int unsigned a);
    case (a)
      HDR_W_FRAME: return 32'h11;
      HDR_W_PPS:   return 32'h22;
      default:     return 32'h0;
    endcase
  endfunction

  assign i_hdr_data = hdr_word(32'(o_hdr_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pop, backpressure rule, payload index tracking
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_fifo_full) begin
        check("wr_while_full", 32'(o_fifo_wr_en), 32'd0);
        check("ready_while_full", 32'(o_payload_ready), 32'd0);
      end
      if (o_fifo_wr_en) begin
        check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("fifo_din", o_fifo_din, exp_q.pop_front());
      end
      if (o_payload_ready && i_payload_valid) pidx++;
    end
  end

  // Stimulus driver for the payload stream and FIFO full
  always @(posedge clk) begin
    #1;
    i_payload_valid = tgl_mode ? ~i_payload_valid : 1'b1;
    i_fifo_full     = force_full | (rnd_full && ($urandom_range(0, 3) == 0));
    i_payload_data  = 32'hA000 + 32'(pidx);
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    i_frame_start = 1'b1;
    @(posedge clk); #1;
    i_frame_start = 1'b0;
  endtask

  task automatic queue_frame();
    pidx = 0;
    for (int a = 0; a < int'(HW); a++) exp_q.push_back(hdr_word(a));
    for (int n = 0; n < int'(PW); n++) exp_q.push_back(32'hA000 + 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
    check({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("rst_rd_en", 32'(o_hdr_rd_en), 32'd0);
    check("rst_addr", 32'(o_hdr_addr), 32'd0);
    check("rst_din", o_fifo_din, 32'd0);
    check("rst_ready", 32'(o_payload_ready), 32'd0);
    check("rst_sent", o_frames_sent, 32'd0);
    check("rst_dropped", 32'(o_frames_dropped), 32'd0);
    rst_n = 1'b1;

    // 1: plain frame
    queue_frame();
    pulse_start();
    wait_idle("t1");
    check("t1_sent", o_frames_sent, 32'd1);
    check("t1_busy", 32'(o_busy), 32'd0);

    // 2: FIFO full for 5 cycles during the push of header word 2
    queue_frame();
    pulse_start();
    n = 0;
    @(negedge clk);
    while (!(o_hdr_rd_en && o_hdr_addr == AW'(2)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t2_reach_w2", 32'(n < 100), 32'd1);
    force_full = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t2_held_in_push", 32'(o_hdr_addr), 32'd2);
    force_full = 1'b0;
    wait_idle("t2");
    check("t2_sent", o_frames_sent, 32'd2);

    // 3: toggling valid and random backpressure
    tgl_mode = 1'b1;
    rnd_full = 1'b1;
    queue_frame();
    pulse_start();
    wait_idle("t3");
    tgl_mode = 1'b0;
    rnd_full = 1'b0;
    check("t3_sent", o_frames_sent, 32'd3);

    // 4: three ignored starts during an active frame
    queue_frame();
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    repeat (100) @(posedge clk);
    pulse_start();
    wait_idle("t4");
    check("t4_dropped", 32'(o_frames_dropped), 32'd3);
    check("t4_sent", o_frames_sent, 32'd4);

    // 5: reset after 100 payload words, then a fresh frame
    queue_frame();
    pulse_start();
    n = 0;
    @(negedge clk);
    while (pidx < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_100", 32'(n < 1000), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(o_busy), 32'd0);
    check("t5_rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("t5_rst_ready", 32'(o_payload_ready), 32'd0);
    check("t5_rst_rd_en", 32'(o_hdr_rd_en), 32'd0);
    check("t5_rst_din", o_fifo_din, 32'd0);
    check("t5_rst_sent", o_frames_sent, 32'd0);
    check("t5_rst_dropped", 32'(o_frames_dropped), 32'd0);
    exp_q.delete();
    pidx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    queue_frame();
    pulse_start();
    @(negedge clk);
    check("t5_restart_addr", 32'(o_hdr_addr), 32'd0);
    wait_idle("t5");
    check("t5_sent", o_frames_sent, 32'd1);

    // 6: drop counter saturation
    @(negedge clk);
    force dut.r_frames_dropped = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.r_frames_dropped;
    @(negedge clk);
    check("t6_preset", 32'(o_frames_dropped), 32'h0000FFFF);
    queue_frame();
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    wait_idle("t6");
    check("t6_saturated", 32'(o_frames_dropped), 32'h0000FFFF);
    check("t6_sent", o_frames_sent, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
